// File: rtl/axi_lite_mult_pkg.sv
// Shared definitions for the AXI4-Lite multiplier engine.
// Contents:
//   - word-index constants for the register map (address bits [4:2])
//   - CTRL / STATUS bit positions
//   - AXI response codes
//   - sequential core FSM state type
package axi_lite_mult_pkg;

  // Register word indices (byte offset = index * 4)
  localparam logic [2:0] REG_OPA    = 3'd0;  // 0x00
  localparam logic [2:0] REG_OPB    = 3'd1;  // 0x04
  localparam logic [2:0] REG_RES_LO = 3'd2;  // 0x08
  localparam logic [2:0] REG_RES_HI = 3'd3;  // 0x0C
  localparam logic [2:0] REG_CTRL   = 3'd4;  // 0x10
  localparam logic [2:0] REG_STATUS = 3'd5;  // 0x14

  // CTRL bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_SIGNED = 1;
  localparam int CTRL_IE     = 2;

  // STATUS bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mult_state_t;

endpackage

// File: rtl/axi_lite_mult_engine_core.sv
// mult_seq_core: radix-2 shift-add multiplier, one partial product per cycle.
// Ports:
//   s2_axi_aclk / s2_axi_aresetn : clock, synchronous active-low reset
//   start, signed_mode, op_a, op_b : operation request, sampled only in IDLE
//   busy    : high while iterating
//   done    : one-cycle strobe during the cycle whose rising edge commits the result
//   product : last committed 2*OP_WIDTH product
//   ovf     : product does not fit in OP_WIDTH bits (per the captured mode)
module mult_seq_core
  import axi_lite_mult_pkg::*;
#(
  parameter int OP_WIDTH = 32
) (
  input  logic                  s2_axi_aclk,
  input  logic                  s2_axi_aresetn,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [OP_WIDTH-1:0]   op_a,
  input  logic [OP_WIDTH-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [2*OP_WIDTH-1:0] product,
  output logic                  ovf
);

  localparam int PW = 2 * OP_WIDTH;
  localparam int CW = $clog2(OP_WIDTH + 1);

  mult_state_t         state_reg, state_next;
  logic [PW-1:0]       acc_reg, acc_next;
  logic [PW-1:0]       mcand_reg, mcand_next;
  logic [OP_WIDTH-1:0] mplr_reg, mplr_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                neg_reg, neg_next;
  logic                sgn_reg, sgn_next;
  logic [PW-1:0]       prod_reg, prod_next;
  logic                ovf_reg, ovf_next;

  logic [OP_WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]       acc_sum, prod_final;
  logic [OP_WIDTH-1:0] upper_half, sign_ext;
  logic                ovf_calc, last_iter;

  // Signed operands are converted to magnitudes; the most negative value
  // still fits because the magnitude is treated as unsigned.
  assign mag_a = (signed_mode && op_a[OP_WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (signed_mode && op_b[OP_WIDTH-1]) ? -op_b : op_b;

  assign acc_sum    = acc_reg + (mplr_reg[0] ? mcand_reg : '0);
  assign prod_final = neg_reg ? -acc_sum : acc_sum;
  assign upper_half = prod_final[PW-1:OP_WIDTH];
  assign sign_ext   = {OP_WIDTH{prod_final[OP_WIDTH-1]}};
  assign ovf_calc   = sgn_reg ? (upper_half != sign_ext) : (upper_half != '0);
  assign last_iter  = (cnt_reg == CW'(OP_WIDTH - 1));

  always_ff @(posedge s2_axi_aclk) begin
    if (!s2_axi_aresetn) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      mcand_reg <= '0;
      mplr_reg  <= '0;
      cnt_reg   <= '0;
      neg_reg   <= 1'b0;
      sgn_reg   <= 1'b0;
      prod_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      mcand_reg <= mcand_next;
      mplr_reg  <= mplr_next;
      cnt_reg   <= cnt_next;
      neg_reg   <= neg_next;
      sgn_reg   <= sgn_next;
      prod_reg  <= prod_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    mcand_next = mcand_reg;
    mplr_next  = mplr_reg;
    cnt_next   = cnt_reg;
    neg_next   = neg_reg;
    sgn_next   = sgn_reg;
    prod_next  = prod_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          acc_next   = '0;
          mcand_next = {{OP_WIDTH{1'b0}}, mag_a};
          mplr_next  = mag_b;
          cnt_next   = '0;
          neg_next   = signed_mode & (op_a[OP_WIDTH-1] ^ op_b[OP_WIDTH-1]);
          sgn_next   = signed_mode;
          ovf_next   = 1'b0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_next   = acc_sum;
        mcand_next = mcand_reg << 1;
        mplr_next  = mplr_reg >> 1;
        cnt_next   = cnt_reg + CW'(1);
        if (last_iter) begin
          prod_next  = prod_final;
          ovf_next   = ovf_calc;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy    = (state_reg == ST_RUN);
  assign done    = (state_reg == ST_RUN) && last_iter;
  assign product = prod_reg;
  assign ovf     = ovf_reg;

endmodule

// File: rtl/axi_lite_mult_engine.sv
// axi_lite_mult_engine: AXI4-Lite slave wrapping a sequential multiplier.
// Ports:
//   s2_axi_aclk / s2_axi_aresetn : clock, synchronous active-low reset
//   s2_axi_aw* / w* / b*         : write address, data and response channels
//   s2_axi_ar* / r*              : read address and data channels
//   irq                          : level interrupt, STATUS.done & CTRL.ie
// Registers (addr[4:2]): OPA, OPB, RES_LO, RES_HI, CTRL, STATUS; others SLVERR.
module axi_lite_mult_engine
  import axi_lite_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int OP_WIDTH   = 32
) (
  input  logic                    s2_axi_aclk,
  input  logic                    s2_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s2_axi_awaddr,
  input  logic                    s2_axi_awvalid,
  output logic                    s2_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s2_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s2_axi_wstrb,
  input  logic                    s2_axi_wvalid,
  output logic                    s2_axi_wready,
  output logic [1:0]              s2_axi_bresp,
  output logic                    s2_axi_bvalid,
  input  logic                    s2_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s2_axi_araddr,
  input  logic                    s2_axi_arvalid,
  output logic                    s2_axi_arready,
  output logic [DATA_WIDTH-1:0]   s2_axi_rdata,
  output logic [1:0]              s2_axi_rresp,
  output logic                    s2_axi_rvalid,
  input  logic                    s2_axi_rready,
  output logic                    irq
);

  localparam int NB = DATA_WIDTH / 8;

  logic                    wr_accept, rd_accept;
  logic [2:0]              wr_idx, rd_idx;
  logic                    bvalid_reg, rvalid_reg;
  logic [1:0]              bresp_reg, bresp_next, rresp_reg, rd_resp;
  logic [DATA_WIDTH-1:0]   rdata_reg, rd_value;

  logic [OP_WIDTH-1:0]     opa_reg, opa_next, opb_reg, opb_next;
  logic                    signed_reg, signed_next;
  logic                    ie_reg, ie_next;
  logic                    done_reg, done_next;

  logic [DATA_WIDTH-1:0]   opa_ext, opb_ext, opa_merged, opb_merged;
  logic                    core_start, core_busy, core_done, core_ovf;
  logic [2*OP_WIDTH-1:0]   core_product;
  logic [2*DATA_WIDTH-1:0] product_ext;
  logic                    unused_bits;

  // Both address and data must be present; no new write while a response is pending.
  assign wr_accept = s2_axi_aresetn & s2_axi_awvalid & s2_axi_wvalid & ~bvalid_reg;
  assign rd_accept = s2_axi_aresetn & s2_axi_arvalid & ~rvalid_reg;
  assign wr_idx    = s2_axi_awaddr[4:2];
  assign rd_idx    = s2_axi_araddr[4:2];

  assign opa_ext     = DATA_WIDTH'(opa_reg);
  assign opb_ext     = DATA_WIDTH'(opb_reg);
  assign product_ext = (2 * DATA_WIDTH)'(core_product);

  // Per-byte merge of write data into the operand registers.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_strb
      assign opa_merged[gi*8 +: 8] = s2_axi_wstrb[gi] ? s2_axi_wdata[gi*8 +: 8] : opa_ext[gi*8 +: 8];
      assign opb_merged[gi*8 +: 8] = s2_axi_wstrb[gi] ? s2_axi_wdata[gi*8 +: 8] : opb_ext[gi*8 +: 8];
    end
  endgenerate

  assign unused_bits = ^{s2_axi_awaddr, s2_axi_araddr, opa_merged, opb_merged};

  // Register write decode
  always_comb begin
    opa_next    = opa_reg;
    opb_next    = opb_reg;
    signed_next = signed_reg;
    ie_next     = ie_reg;
    done_next   = done_reg;
    bresp_next  = RESP_OKAY;
    core_start  = 1'b0;
    if (wr_accept) begin
      case (wr_idx)
        REG_OPA: opa_next = opa_merged[OP_WIDTH-1:0];
        REG_OPB: opb_next = opb_merged[OP_WIDTH-1:0];
        REG_RES_LO, REG_RES_HI: ;
        REG_CTRL: begin
          if (s2_axi_wstrb[0]) begin
            // A start while running is rejected as a whole.
            if (s2_axi_wdata[CTRL_START] && core_busy) begin
              bresp_next = RESP_SLVERR;
            end else begin
              signed_next = s2_axi_wdata[CTRL_SIGNED];
              ie_next     = s2_axi_wdata[CTRL_IE];
              core_start  = s2_axi_wdata[CTRL_START];
            end
          end
        end
        REG_STATUS: begin
          if (s2_axi_wstrb[0] && s2_axi_wdata[STAT_DONE]) done_next = 1'b0;
        end
        default: bresp_next = RESP_SLVERR;
      endcase
    end
    if (core_start) done_next = 1'b0;
    // Completion overrides a same-edge W1C.
    if (core_done) done_next = 1'b1;
  end

  // Register read mux
  always_comb begin
    rd_value = '0;
    rd_resp  = RESP_OKAY;
    case (rd_idx)
      REG_OPA:    rd_value = opa_ext;
      REG_OPB:    rd_value = opb_ext;
      REG_RES_LO: rd_value = product_ext[DATA_WIDTH-1:0];
      REG_RES_HI: rd_value = product_ext[2*DATA_WIDTH-1:DATA_WIDTH];
      REG_CTRL: begin
        rd_value[CTRL_SIGNED] = signed_reg;
        rd_value[CTRL_IE]     = ie_reg;
      end
      REG_STATUS: begin
        rd_value[STAT_BUSY] = core_busy;
        rd_value[STAT_DONE] = done_reg;
        rd_value[STAT_OVF]  = core_ovf;
      end
      default: rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge s2_axi_aclk) begin
    if (!s2_axi_aresetn) begin
      opa_reg    <= '0;
      opb_reg    <= '0;
      signed_reg <= 1'b0;
      ie_reg     <= 1'b0;
      done_reg   <= 1'b0;
      bvalid_reg <= 1'b0;
      bresp_reg  <= RESP_OKAY;
      rvalid_reg <= 1'b0;
      rresp_reg  <= RESP_OKAY;
      rdata_reg  <= '0;
    end else begin
      opa_reg    <= opa_next;
      opb_reg    <= opb_next;
      signed_reg <= signed_next;
      ie_reg     <= ie_next;
      done_reg   <= done_next;
      if (wr_accept) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= bresp_next;
      end else if (s2_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
      if (rd_accept) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_value;
        rresp_reg  <= rd_resp;
      end else if (s2_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  mult_seq_core #(
    .OP_WIDTH(OP_WIDTH)
  ) u_core (
    .s2_axi_aclk   (s2_axi_aclk),
    .s2_axi_aresetn(s2_axi_aresetn),
    .start         (core_start),
    .signed_mode   (s2_axi_wdata[CTRL_SIGNED]),
    .op_a          (opa_reg),
    .op_b          (opb_reg),
    .busy          (core_busy),
    .done          (core_done),
    .product       (core_product),
    .ovf           (core_ovf)
  );

  assign s2_axi_awready = wr_accept;
  assign s2_axi_wready  = wr_accept;
  assign s2_axi_bvalid  = bvalid_reg;
  assign s2_axi_bresp   = bresp_reg;
  assign s2_axi_arready = rd_accept;
  assign s2_axi_rvalid  = rvalid_reg;
  assign s2_axi_rresp   = rresp_reg;
  assign s2_axi_rdata   = rdata_reg;
  assign irq            = done_reg & ie_reg;

endmodule

// File: tb/tb_axi_lite_mult_engine.sv
// Directed bench for axi_lite_mult_engine (default 32/8/32 parameters).
module tb_axi_lite_mult_engine;

  logic        s2_axi_aclk = 1'b0;
  logic        s2_axi_aresetn;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready, irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 s2_axi_aclk = ~s2_axi_aclk;

  axi_lite_mult_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .OP_WIDTH(32)) dut (
    .s2_axi_aclk   (s2_axi_aclk),
    .s2_axi_aresetn(s2_axi_aresetn),
    .s2_axi_awaddr (awaddr),
    .s2_axi_awvalid(awvalid),
    .s2_axi_awready(awready),
    .s2_axi_wdata  (wdata),
    .s2_axi_wstrb  (wstrb),
    .s2_axi_wvalid (wvalid),
    .s2_axi_wready (wready),
    .s2_axi_bresp  (bresp),
    .s2_axi_bvalid (bvalid),
    .s2_axi_bready (bready),
    .s2_axi_araddr (araddr),
    .s2_axi_arvalid(arvalid),
    .s2_axi_arready(arready),
    .s2_axi_rdata  (rdata),
    .s2_axi_rresp  (rresp),
    .s2_axi_rvalid (rvalid),
    .s2_axi_rready (rready),
    .irq           (irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write transaction; returns #1 after the edge that raises bvalid.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n = 0;
    @(negedge s2_axi_aclk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (!(awready && wready) && n < 50) begin
      @(negedge s2_axi_aclk); #1; n++;
    end
    if (n >= 50) check("wr_accept_timeout", 64'd0, 64'd1);
    @(posedge s2_axi_aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_after_write", 64'(bvalid), 64'd1);
    resp = bresp;
    $display("WR addr=0x%02h data=0x%08h strb=%b bresp=%b", addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    @(negedge s2_axi_aclk);
    araddr = addr; arvalid = 1'b1;
    #1;
    while (!arready && n < 50) begin
      @(negedge s2_axi_aclk); #1; n++;
    end
    if (n >= 50) check("rd_accept_timeout", 64'd0, 64'd1);
    @(posedge s2_axi_aclk); #1;
    arvalid = 1'b0;
    check("rvalid_after_read", 64'(rvalid), 64'd1);
    data = rdata; resp = rresp;
    $display("RD addr=0x%02h rdata=0x%08h rresp=%b", addr, data, resp);
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    logic [1:0]  r;
    int n = 0;
    d = 32'h1;
    while (d[0] && n < 100) begin
      axi_read(8'h14, d, r);
      n++;
    end
    if (d[0]) check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  int          lat;

  initial begin
    s2_axi_aresetn = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;   // traffic while in reset
    bready = 1'b1; rready = 1'b1;

    // ---- Reset state ----
    repeat (3) @(posedge s2_axi_aclk);
    #1;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_irq",     64'(irq),     64'd0);
    check("rst_rdata",   64'(rdata),   64'd0);
    check("rst_resps",   64'({bresp, rresp}), 64'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge s2_axi_aclk);
    s2_axi_aresetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      axi_read(8'(i * 4), d, r);
      check($sformatf("rst_read_%0d", i), 64'({r, d}), 64'd0);
    end

    // ---- 7 * 6 unsigned, latency via irq ----
    axi_write(8'h00, 32'd7, 4'hF, r);
    axi_write(8'h04, 32'd6, 4'hF, r);
    axi_write(8'h10, 32'h5, 4'hF, r);            // start, ie
    check("start_bresp", 64'(r), 64'd0);
    lat = 0;
    while (!irq && lat < 100) begin
      @(posedge s2_axi_aclk); #1; lat++;
    end
    check("busy_cycles", 64'(lat), 64'd32);
    axi_read(8'h08, d, r); check("res_lo_42", 64'(d), 64'd42);
    axi_read(8'h0C, d, r); check("res_hi_42", 64'(d), 64'd0);
    axi_read(8'h14, d, r); check("status_42", 64'(d), 64'h2);

    // ---- -1 * 2 signed ----
    axi_write(8'h00, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(8'h04, 32'd2, 4'hF, r);
    axi_write(8'h10, 32'h3, 4'hF, r);
    wait_idle();
    axi_read(8'h08, d, r); check("s_res_lo", 64'(d), 64'hFFFF_FFFE);
    axi_read(8'h0C, d, r); check("s_res_hi", 64'(d), 64'hFFFF_FFFF);
    axi_read(8'h14, d, r); check("s_status", 64'(d), 64'h2);

    // ---- 0xFFFFFFFF * 2 unsigned ----
    axi_write(8'h10, 32'h1, 4'hF, r);
    wait_idle();
    axi_read(8'h08, d, r); check("u_res_lo", 64'(d), 64'hFFFF_FFFE);
    axi_read(8'h0C, d, r); check("u_res_hi", 64'(d), 64'h1);
    axi_read(8'h14, d, r); check("u_status_ovf", 64'(d), 64'h6);

    // ---- most negative * -1 signed: +2^31 overflows ----
    axi_write(8'h00, 32'h8000_0000, 4'hF, r);
    axi_write(8'h04, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(8'h10, 32'h3, 4'hF, r);
    wait_idle();
    axi_read(8'h08, d, r); check("mn_res_lo", 64'(d), 64'h8000_0000);
    axi_read(8'h0C, d, r); check("mn_res_hi", 64'(d), 64'h0);
    axi_read(8'h14, d, r); check("mn_status", 64'(d), 64'h6);

    // ---- start while busy, operand write while busy, done W1C ----
    axi_write(8'h00, 32'd3, 4'hF, r);
    axi_write(8'h04, 32'd5, 4'hF, r);
    axi_write(8'h10, 32'h5, 4'hF, r);
    axi_read(8'h14, d, r);  check("busy_status", 64'(d), 64'h1);
    axi_write(8'h00, 32'd100, 4'hF, r); check("opa_busy_bresp", 64'(r), 64'd0);
    axi_write(8'h10, 32'h1, 4'hF, r);   check("start_busy_bresp", 64'(r), 64'h2);
    wait_idle();
    axi_read(8'h08, d, r);  check("busy_res_lo", 64'(d), 64'd15);
    axi_read(8'h00, d, r);  check("opa_readback", 64'(d), 64'd100);
    check("irq_set", 64'(irq), 64'd1);
    axi_write(8'h14, 32'h2, 4'hF, r);
    axi_read(8'h14, d, r);  check("done_cleared", 64'(d), 64'h0);
    check("irq_cleared", 64'(irq), 64'd0);

    // ---- unmapped, RO write, byte strobes ----
    axi_read(8'h18, d, r);  check("unmapped_rd", 64'({r, d}), {30'd0, 2'b10, 32'd0});
    axi_write(8'h1C, 32'h1234, 4'hF, r); check("unmapped_wr", 64'(r), 64'h2);
    axi_write(8'h08, 32'h1234, 4'hF, r); check("ro_wr_bresp", 64'(r), 64'h0);
    axi_read(8'h08, d, r);  check("ro_unchanged", 64'(d), 64'd15);
    axi_write(8'h00, 32'h0, 4'hF, r);
    axi_write(8'h00, 32'hAABB_CCDD, 4'b0010, r);
    axi_read(8'h00, d, r);  check("opa_wstrb", 64'(d), 64'h0000_CC00);

    // ---- reset during RUN ----
    axi_write(8'h00, 32'd7, 4'hF, r);
    axi_write(8'h04, 32'd6, 4'hF, r);
    axi_write(8'h10, 32'h5, 4'hF, r);
    repeat (9) begin @(posedge s2_axi_aclk); #1; end
    s2_axi_aresetn = 1'b0;
    @(posedge s2_axi_aclk); #1;
    check("midrst_irq", 64'(irq), 64'd0);
    check("midrst_valids", 64'({bvalid, rvalid}), 64'd0);
    s2_axi_aresetn = 1'b1;
    axi_read(8'h14, d, r);  check("midrst_status", 64'(d), 64'h0);
    axi_read(8'h08, d, r);  check("midrst_res_lo", 64'(d), 64'h0);
    axi_read(8'h00, d, r);  check("midrst_opa", 64'(d), 64'h0);
    axi_write(8'h00, 32'd9, 4'hF, r);
    axi_write(8'h04, 32'd9, 4'hF, r);
    axi_write(8'h10, 32'h1, 4'hF, r);
    wait_idle();
    axi_read(8'h08, d, r);  check("after_rst_res", 64'(d), 64'd81);
    axi_read(8'h14, d, r);  check("after_rst_status", 64'(d), 64'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
